// File: rtl/dot_pkg.sv
// Shared defaults, derived widths and the FSM state type for the dot product engine.
package dot_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_N_ELEM = 8;
    localparam int unsigned DEF_B_BASE = 8;
    localparam int unsigned DEF_ADDR_W = 4;

    // Wide enough for N_ELEM full-scale products, so the sum can never overflow.
    localparam int unsigned ACC_W = 2 * DEF_DATA_W + $clog2(DEF_N_ELEM);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        ACC,
        DONE
    } state_e;

endpackage

// File: rtl/dot_product_engine_mac_unit.sv
// Unsigned multiply-accumulate with synchronous clear.
// acc presents the value the accumulator takes at the next edge, so a caller can capture the final sum in the same cycle as the last product.
module mac_unit
    import dot_pkg::*;
#(
    parameter int unsigned DW = DEF_DATA_W,
    parameter int unsigned AW = ACC_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [AW-1:0] acc
);

    logic [2*DW-1:0] prod_c;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_d;

    always_comb begin
        prod_c = (2*DW)'(a) * (2*DW)'(b);
        acc_d  = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + AW'(prod_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_d;

endmodule

// File: rtl/dot_product_engine.sv
// Reads vectors A and B from scratch memory and returns their unsigned dot product.
// Define DOT_SAT_EN to saturate the result at full scale and add the comp_ovf flag.
module dot_product_engine
    import dot_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned N_ELEM = DEF_N_ELEM,
    parameter int unsigned B_BASE = DEF_B_BASE,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              comp_start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy,
    output logic              comp_done,
    output logic [DATA_W-1:0] comp_result
`ifdef DOT_SAT_EN
    ,
    output logic              comp_ovf
`endif
);

    localparam int unsigned IDX_W = $clog2(N_ELEM);
    localparam int unsigned SUM_W = 2 * DATA_W + IDX_W;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mac_clr_c;
    logic                mac_en_c;
    logic [SUM_W-1:0]    acc_nxt;
`ifdef DOT_SAT_EN
    logic                ovf_q, ovf_d;
`endif

    mac_unit #(
        .DW (DATA_W),
        .AW (SUM_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr_c),
        .en  (mac_en_c),
        .a   (a_q),
        .b   (mem_rd_data),
        .acc (acc_nxt)
    );

    // Sequencer: per element RD_A issues A's address, RD_B captures A and issues B's, ACC folds in the product.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        result_d    = result_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mac_clr_c   = 1'b0;
        mac_en_c    = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
`ifdef DOT_SAT_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (comp_start) begin
                    mac_clr_c = 1'b1;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = RD_A;
                end
            end
            RD_A: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = ADDR_W'(idx_q);
                state_d     = RD_B;
            end
            RD_B: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = ADDR_W'(B_BASE) + ADDR_W'(idx_q);
                a_d         = mem_rd_data;
                state_d     = ACC;
            end
            ACC: begin
                mac_en_c = 1'b1;
                if (idx_q == IDX_W'(N_ELEM - 1)) begin
                    // Capture the final sum, including this last product, as DONE is entered.
                    done_d  = 1'b1;
                    state_d = DONE;
`ifdef DOT_SAT_EN
                    ovf_d    = |acc_nxt[SUM_W-1:DATA_W];
                    result_d = ovf_d ? '1 : acc_nxt[DATA_W-1:0];
`else
                    result_d = DATA_W'(acc_nxt);
`endif
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = RD_A;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DOT_SAT_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef DOT_SAT_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign comp_done   = done_q;
    assign comp_result = result_q;
`ifdef DOT_SAT_EN
    assign comp_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_dot_product_engine.sv
// Bench for dot_product_engine: a cycle-timeline model of the expected outputs plus directed vectors.
// Build with DOT_SAT_EN defined to exercise the saturating variant.
module tb_dot_product_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       comp_start;
    logic       mem_rd_en;
    logic [3:0] mem_rd_addr;
    logic [7:0] mem_rd_data;
    logic       busy;
    logic       comp_done;
    logic [7:0] comp_result;
`ifdef DOT_SAT_EN
    logic       comp_ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] mem [16];

    dot_product_engine dut (
        .clk         (clk),
        .rst         (rst),
        .comp_start  (comp_start),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .busy        (busy),
        .comp_done   (comp_done),
        .comp_result (comp_result)
`ifdef DOT_SAT_EN
        ,
        .comp_ovf    (comp_ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read scratch memory; junk on the bus when not reading.
    always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 8'($urandom);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Expected result straight from the arithmetic definition.
    task automatic model_dot(output int val, output int ovf);
        int sum;
        sum = 0;
        for (int i = 0; i < 8; i++) sum += int'(mem[i]) * int'(mem[8 + i]);
`ifdef DOT_SAT_EN
        ovf = (sum >= 256) ? 1 : 0;
        val = (sum >= 256) ? 255 : sum;
`else
        ovf = 0;
        val = sum % 256;
`endif
    endtask

    // Timeline model: a run accepted in cycle s is busy s+1..s+25, reads in s+1..s+24, completes at s+25.
    bit model_ok = 0;
    bit run_on   = 0;
    int run_s    = 0;
    int run_val  = 0;
    int run_ovf  = 0;
    int exp_res  = 0;
    int exp_ovf  = 0;

    always @(negedge clk) begin
        int  k;
        int  ph;
        int  e_addr;
        bit  e_en;
        bit  e_busy;
        bit  e_done;
        if (model_ok) begin
            k      = cyc - run_s;
            ph     = (k - 1) % 3;
            e_busy = run_on && k >= 1 && k <= 25;
            e_done = run_on && k == 25;
            e_en   = run_on && k >= 1 && k <= 24 && ph != 2;
            e_addr = !e_en ? 0 : (ph == 0 ? (k - 1) / 3 : 8 + (k - 1) / 3);
            if (e_done) begin
                exp_res = run_val;
                exp_ovf = run_ovf;
            end
            chk("busy", 32'(busy), 32'(e_busy));
            chk("comp_done", 32'(comp_done), 32'(e_done));
            chk("mem_rd_en", 32'(mem_rd_en), 32'(e_en));
            chk("mem_rd_addr", 32'(mem_rd_addr), 32'(e_addr));
            chk("comp_result", 32'(comp_result), 32'(exp_res));
`ifdef DOT_SAT_EN
            chk("comp_ovf", 32'(comp_ovf), 32'(exp_ovf));
`endif
        end
        if (rst) begin
            run_on   = 0;
            exp_res  = 0;
            exp_ovf  = 0;
            model_ok = 1;
        end else if (comp_start && !run_on) begin
            run_on = 1;
            run_s  = cyc;
            model_dot(run_val, run_ovf);
        end else if (run_on && cyc - run_s >= 25) begin
            run_on = 0;
        end
    end

    task automatic load(input int a_mode, input int b_mode);
        for (int i = 0; i < 8; i++) begin
            mem[i]     = (a_mode < 0) ? 8'(i + 1) : 8'(a_mode);
            mem[8 + i] = (b_mode < 0) ? 8'(i + 1) : 8'(b_mode);
        end
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (comp_done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start(output int s);
        @(posedge clk);
        #1 comp_start = 1'b1;
        s = cyc;
        @(posedge clk);
        #1 comp_start = 1'b0;
    endtask

    task automatic run_vec(input string name, input int exp_r);
        int s;
        int dc;
        pulse_start(s);
        wait_done(dc);
        chk({name, "_latency"}, 32'(dc - s), 32'd25);
        chk({name, "_result"}, 32'(comp_result), 32'(exp_r));
    endtask

    task automatic count_dones(input string name, input int n_cyc);
        int nd;
        nd = 0;
        repeat (n_cyc) begin
            @(negedge clk);
            if (comp_done === 1'b1) nd++;
        end
        chk(name, 32'(nd), 32'd0);
    endtask

    initial begin
        int s;
        int dc;
        rst        = 1'b1;
        comp_start = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_result", 32'(comp_result), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rd_en", 32'(mem_rd_en), 32'd0);

        // A=1..8, B=1
        load(-1, 1);
        run_vec("ramp_ones", 36);

        // A=B=16: sum 2048
        load(16, 16);
`ifdef DOT_SAT_EN
        run_vec("all16", 255);
        chk("all16_ovf", 32'(comp_ovf), 32'd1);
`else
        run_vec("all16", 0);
`endif

        // Zero vector, then A=B=1..8
        load(0, 255);
        run_vec("zero", 0);
`ifdef DOT_SAT_EN
        chk("zero_ovf", 32'(comp_ovf), 32'd0);
`endif
        load(-1, -1);
        run_vec("squares", 204);

        // A second start mid-run is ignored
        load(-1, 1);
        pulse_start(s);
        repeat (9) @(posedge clk);
        #1 comp_start = 1'b1;
        chk("restart_cycle", 32'(cyc - s), 32'd10);
        @(posedge clk);
        #1 comp_start = 1'b0;
        wait_done(dc);
        chk("ignored_start_latency", 32'(dc - s), 32'd25);
        chk("ignored_start_result", 32'(comp_result), 32'd36);
        count_dones("ignored_start_extra_done", 30);

        // Reset mid-run at cycle 12
        pulse_start(s);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_cycle", 32'(cyc - s), 32'd12);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(comp_result), 32'd0);
        count_dones("rst_no_done", 30);
        load(-1, 2);
        run_vec("after_rst", 72);

        // Back-to-back: start in the cycle after done
        load(-1, 1);
        run_vec("b2b_first", 36);
        @(posedge clk);
        #1 comp_start = 1'b1;
        s = cyc;
        load(-1, 2);
        @(posedge clk);
        #1 comp_start = 1'b0;
        @(negedge clk);
        chk("b2b_hold", 32'(comp_result), 32'd36);
        wait_done(dc);
        chk("b2b_second_latency", 32'(dc - s), 32'd25);
        chk("b2b_second_result", 32'(comp_result), 32'd72);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
